// File: rtl/mips_alu_mc.sv
// Multicycle MIPS32 execute-stage ALU: one-cycle logic/arith/shift ops, iterative multu/divu into HI/LO.
// Define ALU_SIGNED_MULDIV_EN to add signed mult (1101) and div (1110) with a sign-fixup state.
module mips_alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = SHW + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_MULTU = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
`ifdef ALU_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULT  = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`endif

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;       // multiplicand or divisor
    logic [WIDTH-1:0]   acc_hi_reg, acc_hi_next;   // partial product high / remainder
    logic [WIDTH-1:0]   acc_lo_reg, acc_lo_next;   // multiplier / dividend-quotient
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               zero_reg, zero_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;

    // Bitwise logic unit
    logic [WIDTH-1:0] and_v, or_v, xor_v, nor_v;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign and_v[gi] = a[gi] & b[gi];
            assign or_v[gi]  = a[gi] | b[gi];
            assign xor_v[gi] = a[gi] ^ b[gi];
            assign nor_v[gi] = ~(a[gi] | b[gi]);
        end
    endgenerate

    logic [WIDTH-1:0] single_res;
    always_comb begin
        single_res = a + b;
        case (alu_control)
            OP_AND:  single_res = and_v;
            OP_OR:   single_res = or_v;
            OP_ADD:  single_res = a + b;
            OP_XOR:  single_res = xor_v;
            OP_SUB:  single_res = a - b;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  single_res = a << shamt;
            OP_SRL:  single_res = a >> shamt;
            OP_SRA:  single_res = $signed(a) >>> shamt;
            OP_NOR:  single_res = nor_v;
            default: single_res = a + b;
        endcase
    end

    // One shift-add multiply step: add multiplicand if LSB set, shift {carry,hi,lo} right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_step, mul_lo_step;
    assign mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    assign mul_hi_step = mul_sum[WIDTH:1];
    assign mul_lo_step = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

    // One restoring divide step; a zero divisor naturally yields q = all ones, rem = dividend.
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_step, div_q_step;
    assign div_trial    = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_ge       = div_trial >= {1'b0, opnd_reg};
    assign div_rem_step = div_ge ? (div_trial[WIDTH-1:0] - opnd_reg) : div_trial[WIDTH-1:0];
    assign div_q_step   = {acc_lo_reg[WIDTH-2:0], div_ge};

`ifdef ALU_SIGNED_MULDIV_EN
    logic             fix_en_reg, fix_en_next;
    logic             fix_div_reg, fix_div_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic             dvz_reg, dvz_next;
    logic [WIDTH-1:0] a_orig_reg, a_orig_next;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign a_mag    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign prod_neg = ~{acc_hi_reg, acc_lo_reg} + (2*WIDTH)'(1);

    always_comb begin
        fix_hi = acc_hi_reg;
        fix_lo = acc_lo_reg;
        if (fix_div_reg) begin
            if (dvz_reg) begin
                fix_lo = '1;
                fix_hi = a_orig_reg;
            end else begin
                fix_lo = neg_q_reg ? (~acc_lo_reg + WIDTH'(1)) : acc_lo_reg;
                fix_hi = neg_r_reg ? (~acc_hi_reg + WIDTH'(1)) : acc_hi_reg;
            end
        end else if (neg_q_reg) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end
`endif

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        opnd_next   = opnd_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        result_next = result_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
`ifdef ALU_SIGNED_MULDIV_EN
        fix_en_next  = fix_en_reg;
        fix_div_next = fix_div_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        dvz_next     = dvz_reg;
        a_orig_next  = a_orig_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    count_next  = CNT_W'(WIDTH);
                    acc_hi_next = '0;
                    acc_lo_next = a;
                    opnd_next   = b;
`ifdef ALU_SIGNED_MULDIV_EN
                    fix_en_next = 1'b0;
`endif
                    case (alu_control)
                        OP_MULTU: state_next = S_MUL;
                        OP_DIVU:  state_next = S_DIV;
`ifdef ALU_SIGNED_MULDIV_EN
                        OP_MULT: begin
                            state_next   = S_MUL;
                            acc_lo_next  = a_mag;
                            opnd_next    = b_mag;
                            fix_en_next  = 1'b1;
                            fix_div_next = 1'b0;
                            neg_q_next   = a[WIDTH-1] ^ b[WIDTH-1];
                        end
                        OP_DIV: begin
                            state_next   = S_DIV;
                            acc_lo_next  = a_mag;
                            opnd_next    = b_mag;
                            fix_en_next  = 1'b1;
                            fix_div_next = 1'b1;
                            neg_q_next   = a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r_next   = a[WIDTH-1];
                            dvz_next     = (b == '0);
                            a_orig_next  = a;
                        end
`endif
                        default: begin
                            result_next = single_res;
                            state_next  = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_hi_next = mul_hi_step;
                acc_lo_next = mul_lo_step;
                count_next  = count_reg - CNT_W'(1);
            end
            S_DIV: begin
                acc_hi_next = div_rem_step;
                acc_lo_next = div_q_step;
                count_next  = count_reg - CNT_W'(1);
            end
`ifdef ALU_SIGNED_MULDIV_EN
            S_FIX: begin
                hi_next     = fix_hi;
                lo_next     = fix_lo;
                result_next = fix_lo;
                state_next  = S_DONE;
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Last engine iteration: publish directly, or hand off to the sign fixup.
        if ((state_reg == S_MUL || state_reg == S_DIV) && count_reg == CNT_W'(1)) begin
`ifdef ALU_SIGNED_MULDIV_EN
            if (fix_en_reg) begin
                state_next = S_FIX;
            end else
`endif
            begin
                hi_next     = acc_hi_next;
                lo_next     = acc_lo_next;
                result_next = acc_lo_next;
                state_next  = S_DONE;
            end
        end

        zero_next = (result_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            opnd_reg   <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            hi_reg     <= '0;
            lo_reg     <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
            fix_en_reg  <= 1'b0;
            fix_div_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dvz_reg     <= 1'b0;
            a_orig_reg  <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            opnd_reg   <= opnd_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
`ifdef ALU_SIGNED_MULDIV_EN
            fix_en_reg  <= fix_en_next;
            fix_div_reg <= fix_div_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            dvz_reg     <= dvz_next;
            a_orig_reg  <= a_orig_next;
`endif
        end
    end

    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign alu_result = result_reg;
    assign zero       = zero_reg;
    assign hi         = hi_reg;
    assign lo         = lo_reg;

endmodule

// File: doc/mips_alu_mc.md
# mips_alu_mc

Multicycle, width-parametrised ALU for the MIPS32 execute stage. Single-cycle logic/arithmetic/shift ops complete one cycle after issue. Multiply and divide run iteratively over WIDTH cycles into HI/LO registers. A start/busy/done handshake lets the pipeline stall on long operations. Opcode encoding is the existing 4-bit alu_control encoding used by the datapath, so the decoder needs no change.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  issue request; sampled only in IDLE
- alu_control  in  4  operation code
- a  in  WIDTH  operand A (shift source for shifts)
- b  in  WIDTH  operand B
- shamt  in  SHW  shift amount for sll/srl/sra
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; result/hi/lo/zero valid from this cycle
- alu_result  out  WIDTH  registered result
- zero  out  1  registered (alu_result == 0)
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient

## Operation
- Opcodes:
  - 0000 and
  - 0001 or
  - 0010 add
  - 0100 xor
  - 0101 multu
  - 0110 sub
  - 0111 slt (unsigned compare, result 1/0)
  - 1000 sll
  - 1001 srl
  - 1010 sra
  - 1011 divu
  - 1100 nor
  - All other codes: add.
- Add and sub wrap modulo 2^WIDTH. No overflow flag.
- Operands a, b, shamt and alu_control are latched on the accepted start. Later input changes have no effect.
- States: IDLE, MUL, DIV, FIX (present only with the config macro), DONE.
- IDLE with start:
  - single-cycle op: compute and register the result, then go to DONE;
  - multu: go to MUL with count = WIDTH;
  - divu: go to DIV with count = WIDTH.
- MUL: shift-add, one multiplier bit per cycle. After WIDTH cycles, {hi,lo} = full 2·WIDTH product, alu_result = lo. Then go to DONE (or FIX).
- DIV: restoring division, one quotient bit per cycle. After WIDTH cycles, lo = quotient, hi = remainder, alu_result = lo. Then go to DONE (or FIX).
- Divide by zero: lo = all ones, hi = a, alu_result = all ones. Same cycle count as a normal divide. No exception.
- DONE: done = 1 for one cycle, then return to IDLE.
- start is ignored while busy, including in DONE.
- Single-cycle ops leave hi/lo unchanged.
- alu_result, zero, hi and lo hold their values until the next completion overwrites them.

## Timing
- Reset values: busy = 0, done = 0, alu_result = 0, zero = 1, hi = 0, lo = 0, state = IDLE.
- Reset asserted mid-operation aborts it: reset values apply on the next edge and no done is produced.
- Single-cycle op with start at edge t: done and result at t+1, accept the next start at t+2.
- multu/divu with start at t: done at t+WIDTH+1.
- Signed mul/div (macro only) with start at t: done at t+WIDTH+2.
- busy rises at t+1 and falls the cycle after done.
- zero updates in the same cycle as alu_result.

## Configuration
- ALU_SIGNED_MULDIV_EN defined:
  - opcode 1101 = mult (signed) and 1110 = div (signed);
  - operands are converted to magnitudes at issue, and the unsigned engine runs on them;
  - the FIX state negates the product, quotient or remainder as required. The remainder takes the sign of the dividend and the quotient truncates toward zero;
  - signed divide by zero gives lo = all ones, hi = a.
- ALU_SIGNED_MULDIV_EN undefined: FIX is absent, and 1101/1110 execute as add in one cycle.

## Test plan
- Reset, then start add, a = 5, b = 7 -> done at the next edge, alu_result = 12, zero = 0, hi = lo = 0.
- sub, a = 3, b = 3 -> alu_result = 0, zero = 1. Then sra, a = 0x80000000, shamt = 4 -> 0xF8000000.
- multu, a = 0xFFFFFFFF, b = 2 -> done exactly 33 cycles after start; hi = 1, lo = alu_result = 0xFFFFFFFE. A start pulsed during busy is ignored.
- divu, a = 100, b = 7 -> lo = 14, hi = 2. Then divu, a = 9, b = 0 -> lo = 0xFFFFFFFF, hi = 9, 33-cycle latency.
- Reset asserted at cycle 10 of a multu -> next cycle busy = 0, hi = lo = 0, no done pulse. A fresh add completes normally afterwards.
- With the macro: div (1110), a = −7, b = 2 -> lo = −3, hi = −1, done at 34 cycles. mult, a = −3, b = 4 -> {hi,lo} = −12. Without the macro: 1101, a = 2, b = 3 -> alu_result = 5 after 1 cycle.
